// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the data-side memory controller: FSM states,
// load/store encodings and the enable-bit positions used by the CPU control unit.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } mem_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam int RD_EN_BIT = 3;
  localparam int WR_EN_BIT = 2;

endpackage

// File: rtl/data_memory_if.sv
// MEM-stage request bus between the CPU (master) and the data memory (slave).
interface data_memory_if;
  logic [3:0]  READ;
  logic [2:0]  WRITE;
  logic [31:0] ADDRESS;
  logic [31:0] WRITEDATA;
  logic [31:0] READDATA;
  logic        BUSYWAIT;

  modport master (
    output READ, WRITE, ADDRESS, WRITEDATA,
    input  READDATA, BUSYWAIT
  );

  modport slave (
    input  READ, WRITE, ADDRESS, WRITEDATA,
    output READDATA, BUSYWAIT
  );
endinterface

// File: rtl/data_memory_load_extend.sv
// Combinational load formatter: picks a byte/half from a 32-bit word by lane
// and sign- or zero-extends it according to the load funct3.
module load_extend_unit
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Byte lane select.
  always_comb begin
    byte_s = 8'h00;
    case (lane)
      2'd0:    byte_s = word[7:0];
      2'd1:    byte_s = word[15:8];
      2'd2:    byte_s = word[23:16];
      2'd3:    byte_s = word[31:24];
      default: byte_s = 8'h00;
    endcase
  end

  // Halfword select ignores lane bit 0, aligning misaligned halves down.
  always_comb begin
    if (lane[1]) begin
      half_s = word[31:16];
    end else begin
      half_s = word[15:0];
    end
  end

  // Extension per funct3; undefined codes yield zero.
  always_comb begin
    result = 32'h0000_0000;
    case (funct3)
      F3_LB:   result = {{24{byte_s[7]}}, byte_s};
      F3_LH:   result = {{16{half_s[15]}}, half_s};
      F3_LW:   result = word;
      F3_LBU:  result = {24'h00_0000, byte_s};
      F3_LHU:  result = {16'h0000, half_s};
      default: result = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// Byte-addressed data memory with fixed access latency, byte-lane masked
// stores and extended loads, stalling the CPU through BUSYWAIT.
module data_memory
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 4
) (
  input  logic          CLK,
  input  logic          RESET,
  data_memory_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  mem_state_e              state_r;
  logic [3:0]              cnt_r;
  logic                    rd_r;
  logic                    wr_r;
  logic [2:0]              funct3_r;
  logic [1:0]              size_r;
  logic [ADDR_WIDTH+1:0]   addr_r;
  logic [31:0]             wdata_r;
  logic [31:0]             readdata_r;
  logic [31:0]             mem_r [DEPTH];

  logic                    req_rd_s;
  logic                    req_wr_s;
  logic                    busy_s;
  logic                    access_s;
  logic                    commit_s;
  logic [ADDR_WIDTH-1:0]   index_s;
  logic [1:0]              lane_s;
  logic [31:0]             word_s;
  logic [31:0]             bit_mask_s;
  logic [31:0]             lanes_data_s;
  logic [31:0]             merged_s;
  logic [31:0]             load_s;
  logic                    unused_s;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] m;
    m = 4'b0000;
    case (size)
      SIZE_B:  m = 4'b0001 << lane;
      SIZE_H:  m = lane[1] ? 4'b1100 : 4'b0011;
      SIZE_W:  m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] expand_mask(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  // Right-aligned store data is replicated so every candidate lane carries it.
  function automatic logic [31:0] replicate_data(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] r;
    r = d;
    case (size)
      SIZE_B:  r = {4{d[7:0]}};
      SIZE_H:  r = {2{d[15:0]}};
      SIZE_W:  r = d;
      default: r = d;
    endcase
    return r;
  endfunction

  assign req_rd_s     = bus.READ[RD_EN_BIT];
  assign req_wr_s     = bus.WRITE[WR_EN_BIT];
  assign index_s      = addr_r[ADDR_WIDTH+1:2];
  assign lane_s       = addr_r[1:0];
  assign word_s       = mem_r[index_s];
  assign access_s     = (state_r == ST_BUSY) && (cnt_r == 4'd0);
  // Gate with RESET so an edge arriving during reset cannot commit a dropped store.
  assign commit_s     = access_s && wr_r && RESET;
  assign bit_mask_s   = expand_mask(lane_mask(size_r, lane_s));
  assign lanes_data_s = replicate_data(size_r, wdata_r);
  assign merged_s     = (word_s & ~bit_mask_s) | (lanes_data_s & bit_mask_s);
  assign unused_s     = ^bus.ADDRESS[31:ADDR_WIDTH+2];

  load_extend_unit u_load_extend (
    .word   (word_s),
    .lane   (lane_s),
    .funct3 (funct3_r),
    .result (load_s)
  );

  // Stall request: combinational in IDLE so the CPU stalls in the request cycle.
  always_comb begin
    busy_s = 1'b0;
    case (state_r)
      ST_IDLE: busy_s = req_rd_s | req_wr_s;
      ST_BUSY: busy_s = 1'b1;
      ST_DONE: busy_s = 1'b0;
      default: busy_s = 1'b0;
    endcase
  end

  assign bus.BUSYWAIT = busy_s;
  assign bus.READDATA = readdata_r;

  // Access FSM: capture request, count down latency, perform access, then one DONE cycle.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 4'd0;
      rd_r       <= 1'b0;
      wr_r       <= 1'b0;
      funct3_r   <= 3'd0;
      size_r     <= 2'd0;
      addr_r     <= {(ADDR_WIDTH+2){1'b0}};
      wdata_r    <= 32'h0000_0000;
      readdata_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_rd_s || req_wr_s) begin
            rd_r     <= req_rd_s;
            wr_r     <= req_wr_s;
            funct3_r <= bus.READ[2:0];
            size_r   <= bus.WRITE[1:0];
            addr_r   <= bus.ADDRESS[ADDR_WIDTH+1:0];
            wdata_r  <= bus.WRITEDATA;
            cnt_r    <= 4'(LATENCY - 1);
            state_r  <= ST_BUSY;
          end else begin
            state_r  <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (cnt_r == 4'd0) begin
            if (rd_r && wr_r) begin
              readdata_r <= 32'h0000_0000;
            end else if (rd_r) begin
              readdata_r <= load_s;
            end else begin
              readdata_r <= readdata_r;
            end
            state_r <= ST_DONE;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ST_DONE: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Storage array is never reset; a store lands on the edge entering DONE.
  always_ff @(posedge CLK) begin
    if (commit_s) begin
      mem_r[index_s] <= merged_s;
    end else begin
      mem_r[index_s] <= mem_r[index_s];
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed, table-driven bench for data_memory with hand-computed expectations.
module tb_data_memory;

  localparam int AW  = 10;
  localparam int LAT = 4;

  logic CLK = 1'b0;
  logic RESET;

  always #5 CLK = ~CLK;

  data_memory_if bus ();

  data_memory #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [3:0]  rd;
    logic [2:0]  wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    bit          gap;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic add(input string n, input logic [3:0] rd, input logic [2:0] wr,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] e, input bit g);
    vec_t v;
    v.name = n; v.rd = rd; v.wr = wr; v.addr = a; v.wdata = d; v.exp = e; v.gap = g;
    vecs.push_back(v);
  endtask

  // Drives a request and holds it until the edge ending DONE; reports stall length and DONE-cycle data.
  task automatic access(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] a,
                        input logic [31:0] d, output int busy_n, output logic [31:0] rdata);
    bus.READ = rd; bus.WRITE = wr; bus.ADDRESS = a; bus.WRITEDATA = d;
    busy_n = 0;
    rdata  = 32'h0000_0000;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (bus.BUSYWAIT) busy_n++;
      else begin
        rdata = bus.READDATA;
        break;
      end
    end
    @(posedge CLK); #1;
  endtask

  task automatic idle();
    bus.READ = 4'b0000; bus.WRITE = 3'b000;
    @(posedge CLK); #1;
  endtask

  int          busy_n;
  logic [31:0] rdata;

  initial begin
    bus.READ = 4'b0000; bus.WRITE = 3'b000;
    bus.ADDRESS = 32'h0; bus.WRITEDATA = 32'h0;
    RESET = 1'b0;

    //            name          READ     WRITE    ADDRESS         WRITEDATA       expected        gap
    add("sw_10",     4'b0000, 3'b110, 32'h0000_0010, 32'h1111_1111, 32'h0000_0000, 1'b1);
    add("sw_20",     4'b0000, 3'b110, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0);
    add("lw_20",     4'b1010, 3'b000, 32'h0000_0020, 32'h0,         32'hDEAD_BEEF, 1'b0);
    add("sb_21",     4'b0000, 3'b100, 32'h0000_0021, 32'h0000_0080, 32'hDEAD_BEEF, 1'b0);
    add("sh_22",     4'b0000, 3'b101, 32'h0000_0022, 32'h0000_1234, 32'hDEAD_BEEF, 1'b1);
    add("lw_merged", 4'b1010, 3'b000, 32'h0000_0020, 32'h0,         32'h1234_80EF, 1'b0);
    add("lb_21",     4'b1000, 3'b000, 32'h0000_0021, 32'h0,         32'hFFFF_FF80, 1'b0);
    add("lbu_21",    4'b1100, 3'b000, 32'h0000_0021, 32'h0,         32'h0000_0080, 1'b1);
    add("lh_22",     4'b1001, 3'b000, 32'h0000_0022, 32'h0,         32'h0000_1234, 1'b0);
    add("lh_23",     4'b1001, 3'b000, 32'h0000_0023, 32'h0,         32'h0000_1234, 1'b0);
    add("sw_40",     4'b0000, 3'b110, 32'h0000_0040, 32'h8000_7FFF, 32'h0000_1234, 1'b0);
    add("lhu_42",    4'b1101, 3'b000, 32'h0000_0042, 32'h0,         32'h0000_8000, 1'b0);
    add("lh_42",     4'b1001, 3'b000, 32'h0000_0042, 32'h0,         32'hFFFF_8000, 1'b0);
    add("lh_40",     4'b1001, 3'b000, 32'h0000_0040, 32'h0,         32'h0000_7FFF, 1'b0);
    add("lb_40",     4'b1000, 3'b000, 32'h0000_0040, 32'h0,         32'hFFFF_FFFF, 1'b0);
    add("lbu_43",    4'b1100, 3'b000, 32'h0000_0043, 32'h0,         32'h0000_0080, 1'b0);
    add("undef_f3",  4'b1011, 3'b000, 32'h0000_0020, 32'h0,         32'h0000_0000, 1'b0);
    add("lw_misal",  4'b1010, 3'b000, 32'h0000_0022, 32'h0,         32'h1234_80EF, 1'b1);
    add("lw_wrap",   4'b1010, 3'b000, 32'h0000_1020, 32'h0,         32'h1234_80EF, 1'b0);
    add("rd_wr_30",  4'b1010, 3'b110, 32'h0000_0030, 32'h55AA_55AA, 32'h0000_0000, 1'b0);
    add("lw_30",     4'b1010, 3'b000, 32'h0000_0030, 32'h0,         32'h55AA_55AA, 1'b0);
    add("sb_33",     4'b0000, 3'b100, 32'h0000_0033, 32'h0000_00C3, 32'h55AA_55AA, 1'b0);
    add("lw_30_b",   4'b1010, 3'b000, 32'h0000_0030, 32'h0,         32'hC3AA_55AA, 1'b1);

    // Reset state, with and without a request on the bus.
    #1;
    check("rst_readdata", bus.READDATA, 32'h0000_0000);
    check("rst_busy_noreq", {31'd0, bus.BUSYWAIT}, 32'd0);
    bus.READ = 4'b1010;
    #1;
    check("rst_busy_req", {31'd0, bus.BUSYWAIT}, 32'd1);
    bus.READ = 4'b0000;
    @(negedge CLK); RESET = 1'b1;
    @(posedge CLK); #1;

    foreach (vecs[i]) begin
      if (vecs[i].gap) idle();
      access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, busy_n, rdata);
      check({vecs[i].name, "_busy"}, busy_n, LAT + 1);
      check(vecs[i].name, rdata, vecs[i].exp);
    end

    // DONE ignores the still-held request; the next IDLE cycle with no request does not stall.
    idle();
    check("idle_after_done", {31'd0, bus.BUSYWAIT}, 32'd0);
    check("readdata_stable", bus.READDATA, 32'hC3AA_55AA);

    // Reset mid-BUSY drops the pending store and clears READDATA.
    bus.READ = 4'b0000; bus.WRITE = 3'b110;
    bus.ADDRESS = 32'h0000_0010; bus.WRITEDATA = 32'hCAFE_F00D;
    @(posedge CLK); @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    bus.WRITE = 3'b000;
    #1;
    check("midbusy_rst_readdata", bus.READDATA, 32'h0000_0000);
    check("midbusy_rst_busy", {31'd0, bus.BUSYWAIT}, 32'd0);
    @(posedge CLK); @(posedge CLK);
    @(negedge CLK); RESET = 1'b1;
    @(posedge CLK); #1;
    check("post_rst_idle", {31'd0, bus.BUSYWAIT}, 32'd0);
    access(4'b1010, 3'b000, 32'h0000_0010, 32'h0, busy_n, rdata);
    check("post_rst_lw_busy", busy_n, LAT + 1);
    check("post_rst_lw_10", rdata, 32'h1111_1111);
    idle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
